spi_slave_multi: RTL and testbench
==================================

# spi_slave_multi

Parametrised next-generation SPI slave for the USB-CDC debugger fabric. Generalises the byte-wide slave to:
- configurable word width and FIFO depth;
- per-frame word length and bit order;
- standard CPOL/CPHA handling;
- explicit MISO output-enable;
- error/status reporting (underrun, overrun, partial word, frame done).

Runs entirely in the system clock domain and sits between the SPI pins (tri-stated at top level) and the protocol/command layer.

## Interface
- Reset: one clock; reset is asynchronous and active-high.
- DATA_WIDTH, 8, maximum word width in bits (4..32)
- FIFO_DEPTH_BITS, 4, log2 depth of TX and RX FIFOs
- SYNC_STAGES, 3, input synchroniser depth (>=2)
- TX_FILL, all ones, word driven when TX FIFO is empty
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- spi_cs, spi_sck, spi_mosi  in  1 each  raw SPI pins
- spi_miso  out  1  serial data out
- spi_miso_oe  out  1  pad enable, 1 only while frame active
- cfg_cpol, cfg_cpha, cfg_lsb_first  in  1 each  mode controls
- cfg_word_len  in  6  bits per word; 0 or >DATA_WIDTH means DATA_WIDTH
- tx_valid  in  1 / tx_data  in  DATA_WIDTH / tx_ready  out  1  TX push, ready = FIFO not full
- rx_valid  out  1 / rx_data  out  DATA_WIDTH / rx_pop  in  1  RX FIFO head, show-ahead
- busy  out  1  frame active
- frame_done  out  1  one-cycle pulse at frame end
- err_clr  in  1  clears sticky flags
- tx_underrun, rx_overrun, rx_partial  out  1 each  sticky errors

## Operation
- Sync: each pin passes through SYNC_STAGES flops; cs syncs to 1 on reset. Edges are detected on the last two stages; sck is XORed with latched cpol.
- Edge roles:
  - CPHA=0: sample on leading edge, shift on trailing edge.
  - CPHA=1: shift on leading edge, sample on trailing edge.
- FSM states IDLE, ACTIVE, DONE.
  - IDLE to ACTIVE on cs fall. Latch cpol/cpha/lsb_first/word_len (mid-frame cfg changes ignored), clear bit counter, load first TX word.
  - If CPHA=0, also drive the first bit immediately.
  - ACTIVE to DONE on cs rise; DONE to IDLE after one cycle, pulsing frame_done.
- TX word load pops the FIFO. If the FIFO is empty, load TX_FILL and set tx_underrun.
  - Short words use tx_data[len-1:0].
  - MSB-first sends bit len-1 first; LSB-first sends bit 0 first.
- RX: shifter assembles len bits, right-aligned and zero-extended.
  - On the len-th sample, the word is written to the RX FIFO the next cycle.
  - If the RX FIFO is full, the word is dropped and rx_overrun is set.
  - The next TX word loads on the same sample edge, so the following shift edge emits its first bit.
- Words are back-to-back with no gap bits, unlimited per frame.
- cs rise with bit counter non-zero: discard partial bits, set rx_partial.
- Sticky flags: set has priority over err_clr in the same cycle.
- spi_miso_oe = busy; spi_miso holds 1 when not driving.

## Timing
- Reset values:
  - spi_miso=1, spi_miso_oe=0, busy=0, frame_done=0, all sticky flags=0.
  - rx_valid=0, rx_data=0, tx_ready=1, FIFOs empty.
- Reset mid-frame aborts the frame and empties both FIFOs. No frame_done.
- Pin-to-action latency: SYNC_STAGES+1 clk.
- SCK high and low phases must each last at least SYNC_STAGES+3 clk. CS fall to first SCK edge must be at least SYNC_STAGES+3 clk.
- RX word visible on rx_valid 2 clk after detection of its last sample edge.
- tx_ready: a push while full is ignored. Simultaneous push and pop on a full FIFO: pop first, push accepted.
- rx_pop with RX FIFO empty is ignored.
- cs rise and a sample edge detected in the same cycle: cs rise wins, and the edge is ignored.

## Structure
- Shared package `spi_pkg` holds:
  - state encoding (IDLE/ACTIVE/DONE);
  - the 6-bit word-length type;
  - the length-clamp function used by all SPI blocks.
- Sub-module: two instances of the existing sync_fifo (DATA_WIDTH wide, FIFO_DEPTH_BITS deep). The sync/edge-detect stage stays inline.

## Test plan
- Mode 0, len 8, MSB-first: push 0xA5, master sends 0x3C. Required: master reads 0xA5, rx_data=0x3C, frame_done pulses once.
- All four CPOL/CPHA modes, DATA_WIDTH=16, len 12, LSB-first: push 0x0ABC, master sends 0x0123. Required: exact round-trip both ways.
- TX FIFO empty, 2-word frame: both words read 0xFF, tx_underrun=1; err_clr clears it.
- RX FIFO depth 16 with no pops, 17 words sent: first 16 stored in order, word 17 dropped, rx_overrun=1.
- cs rises after 5 bits: no RX write, rx_partial=1, spi_miso_oe=0, busy=0.
- rst asserted mid-word: all outputs at reset values, FIFOs empty. Next frame works normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave blocks: FSM states, word-length type,
// and the word-length clamp applied to every configured frame.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } spi_state_e;

  typedef logic [5:0] word_len_t;

  // A length of zero, or one wider than the datapath, selects the full width.
  function automatic word_len_t clamp_len(input word_len_t len, input int unsigned max_w);
    if (len == '0 || 32'(len) > max_w) begin
      return word_len_t'(max_w);
    end
    return len;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. A push while full is accepted only when a pop
// frees a slot in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = count[DEPTH_BITS];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_multi.sv
// Parametrised SPI slave: synchronised pins, CPOL/CPHA edge roles, per-frame
// word length and bit order, TX/RX FIFOs and sticky error reporting.
module spi_slave_multi
  import spi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH      = 8,
  parameter int unsigned           FIFO_DEPTH_BITS = 4,
  parameter int unsigned           SYNC_STAGES     = 3,
  parameter logic [DATA_WIDTH-1:0] TX_FILL         = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_cs,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  input  logic [5:0]            cfg_word_len,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_pop,
  output logic                  busy,
  output logic                  frame_done,
  input  logic                  err_clr,
  output logic                  tx_underrun,
  output logic                  rx_overrun,
  output logic                  rx_partial
);

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;

  spi_state_e            state;
  logic                  cpol_l, cpha_l, lsb_l;
  word_len_t             len_l;
  word_len_t             bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic                  miso_q;
  logic                  rx_wr_pend;
  logic [DATA_WIDTH-1:0] rx_word;

  logic                  cs_fall, cs_rise;
  logic                  sck_cur, sck_old, lead_edge, trail_edge;
  logic                  sample_edge, shift_edge;
  logic                  mosi_bit, word_last, tx_load;

  logic                  eff_lsb;
  word_len_t             eff_len;
  logic [DATA_WIDTH-1:0] tx_word, tx_aligned, tx_after_first;
  logic                  tx_first_bit;
  logic [DATA_WIDTH-1:0] rx_next, rx_aligned;

  logic [DATA_WIDTH-1:0] tx_dout, rx_dout;
  logic                  tx_empty, tx_full, rx_empty, rx_full;

  // Pin synchronisers; cs idles deasserted out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign cs_fall    = cs_sync[SYNC_STAGES-1] & ~cs_sync[SYNC_STAGES-2];
  assign cs_rise    = ~cs_sync[SYNC_STAGES-1] & cs_sync[SYNC_STAGES-2];
  assign sck_cur    = sck_sync[SYNC_STAGES-2] ^ cpol_l;
  assign sck_old    = sck_sync[SYNC_STAGES-1] ^ cpol_l;
  assign lead_edge  = ~sck_old & sck_cur;
  assign trail_edge = sck_old & ~sck_cur;
  assign mosi_bit   = mosi_sync[SYNC_STAGES-2];

  // cs rise takes precedence over any SCK edge seen in the same cycle.
  assign sample_edge = (state == ST_ACTIVE) && !cs_rise && (cpha_l ? trail_edge : lead_edge);
  assign shift_edge  = (state == ST_ACTIVE) && !cs_rise && (cpha_l ? lead_edge : trail_edge);
  assign word_last   = (bit_cnt == len_l - 6'd1);
  assign tx_load     = ((state == ST_IDLE) && cs_fall) || (sample_edge && word_last);

  // TX word alignment and RX assembly. MSB-first TX words are left-justified
  // so the outgoing bit is always the top bit; LSB-first RX words arrive at
  // the top and are shifted down into right-aligned position on completion.
  always_comb begin
    eff_lsb = lsb_l;
    eff_len = len_l;
    if (state == ST_IDLE) begin
      eff_lsb = cfg_lsb_first;
      eff_len = clamp_len(cfg_word_len, DATA_WIDTH);
    end
    tx_word        = tx_empty ? TX_FILL : tx_dout;
    tx_aligned     = eff_lsb ? tx_word : (tx_word << (6'(DATA_WIDTH) - eff_len));
    tx_first_bit   = eff_lsb ? tx_aligned[0] : tx_aligned[DATA_WIDTH-1];
    tx_after_first = eff_lsb ? (tx_aligned >> 1) : (tx_aligned << 1);
    rx_next        = lsb_l ? {mosi_bit, rx_sh[DATA_WIDTH-1:1]}
                           : {rx_sh[DATA_WIDTH-2:0], mosi_bit};
    rx_aligned     = lsb_l ? (rx_next >> (6'(DATA_WIDTH) - len_l)) : rx_next;
  end

  // Frame FSM, shifters and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      lsb_l      <= 1'b0;
      len_l      <= word_len_t'(DATA_WIDTH);
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      miso_q     <= 1'b1;
      rx_wr_pend <= 1'b0;
      rx_word    <= '0;
    end else begin
      rx_wr_pend <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_ACTIVE;
            cpol_l  <= cfg_cpol;
            cpha_l  <= cfg_cpha;
            lsb_l   <= cfg_lsb_first;
            len_l   <= eff_len;
            bit_cnt <= '0;
            rx_sh   <= '0;
            if (cfg_cpha) begin
              tx_sh <= tx_aligned;
            end else begin
              miso_q <= tx_first_bit;
              tx_sh  <= tx_after_first;
            end
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state   <= ST_DONE;
            bit_cnt <= '0;
            rx_sh   <= '0;
          end else if (sample_edge) begin
            if (word_last) begin
              bit_cnt    <= '0;
              rx_sh      <= '0;
              rx_wr_pend <= 1'b1;
              rx_word    <= rx_aligned;
              tx_sh      <= tx_aligned;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              rx_sh   <= rx_next;
            end
          end else if (shift_edge) begin
            miso_q <= lsb_l ? tx_sh[0] : tx_sh[DATA_WIDTH-1];
            tx_sh  <= lsb_l ? (tx_sh >> 1) : (tx_sh << 1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new set event wins over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      rx_partial  <= 1'b0;
    end else begin
      tx_underrun <= (tx_load & tx_empty) | (tx_underrun & ~err_clr);
      rx_overrun  <= (rx_wr_pend & rx_full & ~rx_pop) | (rx_overrun & ~err_clr);
      rx_partial  <= ((state == ST_ACTIVE) & cs_rise & (bit_cnt != '0))
                     | (rx_partial & ~err_clr);
    end
  end

  sync_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (tx_load),
    .dout  (tx_dout),
    .empty (tx_empty),
    .full  (tx_full)
  );

  sync_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_wr_pend),
    .din   (rx_word),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign busy        = (state == ST_ACTIVE);
  assign frame_done  = (state == ST_DONE);
  assign spi_miso_oe = busy;
  assign spi_miso    = busy ? miso_q : 1'b1;
  assign tx_ready    = ~tx_full;
  assign rx_valid    = ~rx_empty;
  assign rx_data     = rx_empty ? '0 : rx_dout;

endmodule

// File: tb/tb_spi_slave_multi.sv
// Directed bench for spi_slave_multi (DATA_WIDTH=16) with a bit-banged master.
module tb_spi_slave_multi;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_cs, spi_sck, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic [5:0]  cfg_word_len;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_pop;
  logic        busy, frame_done, err_clr;
  logic        tx_underrun, rx_overrun, rx_partial;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          fd_cnt   = 0;
  int          fd_before;
  logic        mid_oe;
  logic [15:0] m_tx [32];
  logic [15:0] m_rx [32];

  spi_slave_multi #(
    .DATA_WIDTH      (16),
    .FIFO_DEPTH_BITS (4),
    .SYNC_STAGES     (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .spi_cs        (spi_cs),
    .spi_sck       (spi_sck),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .cfg_cpol      (cfg_cpol),
    .cfg_cpha      (cfg_cpha),
    .cfg_lsb_first (cfg_lsb_first),
    .cfg_word_len  (cfg_word_len),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_pop        (rx_pop),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_clr       (err_clr),
    .tx_underrun   (tx_underrun),
    .rx_overrun    (rx_overrun),
    .rx_partial    (rx_partial)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_tx(input logic [15:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_rx();
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  // Master: drives m_tx bits, captures the slave's bits into m_rx.
  task automatic spi_frame(input logic cpol, input logic cpha, input logic lsb,
                           input int len, input int total_bits);
    int w, b, idx;
    cfg_cpol      = cpol;
    cfg_cpha      = cpha;
    cfg_lsb_first = lsb;
    cfg_word_len  = 6'(len);
    spi_sck       = cpol;
    for (int i = 0; i < 32; i++) m_rx[i] = '0;
    repeat (10) @(negedge clk);
    spi_cs = 1'b0;
    if (!cpha) spi_mosi = m_tx[0][lsb ? 0 : len - 1];
    repeat (10) @(negedge clk);
    mid_oe = spi_miso_oe;
    for (int k = 0; k < total_bits; k++) begin
      w   = k / len;
      b   = k % len;
      idx = lsb ? b : len - 1 - b;
      if (cpha) spi_mosi = m_tx[w][idx];
      spi_sck = ~cpol;
      if (!cpha) m_rx[w][idx] = spi_miso;
      repeat (HALF) @(negedge clk);
      spi_sck = cpol;
      if (cpha) begin
        m_rx[w][idx] = spi_miso;
      end else if (k + 1 < total_bits) begin
        w   = (k + 1) / len;
        b   = (k + 1) % len;
        idx = lsb ? b : len - 1 - b;
        spi_mosi = m_tx[w][idx];
      end
      repeat (HALF) @(negedge clk);
    end
    spi_cs = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_word_len = 6'd8;
    tx_valid = 1'b0; tx_data = '0; rx_pop = 1'b0; err_clr = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_miso", spi_miso, 1);
    check_eq("rst_oe", spi_miso_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flags", {tx_underrun, rx_overrun, rx_partial}, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_fd", fd_cnt, 0);

    // Mode 0, len 8, MSB-first
    push_tx(16'h00A5);
    m_tx[0] = 16'h003C;
    spi_frame(1'b0, 1'b0, 1'b0, 8, 8);
    check_eq("m0_oe_mid", mid_oe, 1);
    check_eq("m0_master_rx", m_rx[0], 16'h00A5);
    check_eq("m0_rx_valid", rx_valid, 1);
    check_eq("m0_rx_data", rx_data, 16'h003C);
    check_eq("m0_frame_done", fd_cnt, 1);
    check_eq("m0_busy_after", busy, 0);
    // The next word is prefetched on the final sample edge from an empty FIFO.
    check_eq("m0_prefetch_underrun", tx_underrun, 1);
    pop_rx();
    pulse_err_clr();
    check_eq("m0_underrun_clr", tx_underrun, 0);

    // All four modes, len 12, LSB-first
    for (int m = 0; m < 4; m++) begin
      logic [1:0] mode;
      mode = 2'(m);
      push_tx(16'h0ABC);
      m_tx[0] = 16'h0123;
      spi_frame(mode[1], mode[0], 1'b1, 12, 12);
      check_eq($sformatf("mode%0d_master_rx", m), m_rx[0], 16'h0ABC);
      check_eq($sformatf("mode%0d_rx_data", m), rx_data, 16'h0123);
      pop_rx();
    end
    check_eq("modes_rx_empty", rx_valid, 0);

    // TX FIFO empty, two-word frame
    pulse_err_clr();
    m_tx[0] = 16'h0012;
    m_tx[1] = 16'h0034;
    spi_frame(1'b0, 1'b0, 1'b0, 8, 16);
    check_eq("uf_word0", m_rx[0], 16'h00FF);
    check_eq("uf_word1", m_rx[1], 16'h00FF);
    check_eq("uf_flag", tx_underrun, 1);
    check_eq("uf_rx0", rx_data, 16'h0012);
    pop_rx();
    check_eq("uf_rx1", rx_data, 16'h0034);
    pop_rx();
    pulse_err_clr();
    check_eq("uf_clr", tx_underrun, 0);

    // TX full handling plus RX overrun on a 17-word frame
    for (int i = 0; i < 16; i++) push_tx(16'(16'h0080 + i));
    check_eq("txfull_ready", tx_ready, 0);
    push_tx(16'h00EE);
    for (int i = 0; i < 17; i++) m_tx[i] = 16'(16'h0040 + i);
    spi_frame(1'b0, 1'b0, 1'b0, 8, 17 * 8);
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("txfull_master_w%0d", i), m_rx[i], 16'(16'h0080 + i));
    check_eq("txfull_fill_w16", m_rx[16], 16'h00FF);
    check_eq("ovr_flag", rx_overrun, 1);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("ovr_rx_w%0d", i), rx_data, 16'(16'h0040 + i));
      pop_rx();
    end
    check_eq("ovr_drained", rx_valid, 0);
    pulse_err_clr();
    check_eq("ovr_clr", rx_overrun, 0);

    // cs rises after 5 bits
    fd_before = fd_cnt;
    m_tx[0] = 16'h00F0;
    spi_frame(1'b0, 1'b0, 1'b0, 8, 5);
    check_eq("part_rx_valid", rx_valid, 0);
    check_eq("part_flag", rx_partial, 1);
    check_eq("part_oe", spi_miso_oe, 0);
    check_eq("part_busy", busy, 0);
    check_eq("part_fd", fd_cnt, fd_before + 1);

    // Reset mid-word: leave an RX word and queued TX words, then abort
    m_tx[0] = 16'h0077;
    spi_frame(1'b0, 1'b0, 1'b0, 8, 8);
    check_eq("abort_pre_rx", rx_data, 16'h0077);
    push_tx(16'h0011);
    push_tx(16'h0022);
    spi_sck = 1'b0;
    spi_mosi = 1'b1;
    spi_cs = 1'b0;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    check_eq("abort_busy_pre", busy, 1);
    fd_before = fd_cnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("abort_miso", spi_miso, 1);
    check_eq("abort_oe", spi_miso_oe, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_flags", {tx_underrun, rx_overrun, rx_partial}, 0);
    check_eq("abort_rx_valid", rx_valid, 0);
    check_eq("abort_rx_data", rx_data, 0);
    check_eq("abort_tx_ready", tx_ready, 1);
    spi_cs = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("abort_no_fd", fd_cnt, fd_before);
    check_eq("abort_idle_rx", rx_valid, 0);

    // Normal frame after abort; TX FIFO must not hold the stale 0x22
    push_tx(16'h005A);
    m_tx[0] = 16'h00C3;
    spi_frame(1'b0, 1'b0, 1'b0, 8, 8);
    check_eq("post_master_rx", m_rx[0], 16'h005A);
    check_eq("post_rx_data", rx_data, 16'h00C3);
    check_eq("post_fd", fd_cnt, fd_before + 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
